// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed seven-segment scan driver:
// active-low {a,b,c,d,e,f,g} glyphs (a at MSB) and output polarities.
package seg_pkg;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Both segments/dp and anodes are driven low to light.
  localparam logic SEG_ON  = 1'b0;
  localparam logic SEG_OFF = 1'b1;
  localparam logic AN_ON   = 1'b0;
  localparam logic AN_OFF  = 1'b1;

endpackage

// File: rtl/seg_nibble_decode.sv
// Combinational nibble-to-glyph decoder; hex digits A..F are shown only
// when hex_en is set, and blank forces every segment off.
module seg_nibble_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_en,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (nibble)
        4'h0: seg = SEG_0;
        4'h1: seg = SEG_1;
        4'h2: seg = SEG_2;
        4'h3: seg = SEG_3;
        4'h4: seg = SEG_4;
        4'h5: seg = SEG_5;
        4'h6: seg = SEG_6;
        4'h7: seg = SEG_7;
        4'h8: seg = SEG_8;
        4'h9: seg = SEG_9;
        4'hA: seg = hex_en ? SEG_A : SEG_BLANK;
        4'hB: seg = hex_en ? SEG_B : SEG_BLANK;
        4'hC: seg = hex_en ? SEG_C : SEG_BLANK;
        4'hD: seg = hex_en ? SEG_D : SEG_BLANK;
        4'hE: seg = hex_en ? SEG_E : SEG_BLANK;
        default: seg = hex_en ? SEG_F : SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment driver: one digit per REFRESH_DIV cycles,
// shadow/display double buffering so a frame never shows mixed data.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int HEX_EN      = 0,
  parameter int LZ_BLANK    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp_in,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*N_DIGITS-1:0]   shadow_val, disp_val;
  logic [N_DIGITS-1:0]     shadow_dp, disp_dp;
  logic                    wrap, frame;

  assign wrap  = (cnt == CNT_LAST);
  assign frame = wrap && (idx == IDX_LAST);
  assign frame_done = frame && !rst;

  // load is a fire-and-forget strobe (no ready): any cycle with load=1 and
  // rst=0 captures value/dp_in; a later load in the same frame overwrites it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      disp_val   <= '0;
      disp_dp    <= '0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      if (load) begin
        shadow_val <= value;
        shadow_dp  <= dp_in;
      end
      // A load landing on the boundary bypasses the shadow straight to display.
      if (frame) begin
        disp_val <= load ? value : shadow_val;
        disp_dp  <= load ? dp_in : shadow_dp;
      end
    end
  end

  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_lz;
  logic                zero_above;
  logic [N_DIGITS-1:0] an_next;
  logic                blank;
  logic [6:0]          dec_seg;

  // Walk from the top digit down; zero_above holds while every digit at or
  // above position i is zero, which marks i as a leading zero.
  always_comb begin
    cur_nib    = '0;
    cur_dp     = 1'b0;
    cur_lz     = 1'b0;
    zero_above = 1'b1;
    an_next    = '1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (disp_val[4*i +: 4] == 4'd0);
      if (idx == IW'(i)) begin
        cur_nib    = disp_val[4*i +: 4];
        cur_dp     = disp_dp[i];
        cur_lz     = zero_above && (i != 0);
        an_next[i] = AN_ON;
      end
    end
  end

  assign blank = (LZ_BLANK != 0) && cur_lz;

  seg_nibble_decode u_decode (
    .nibble (cur_nib),
    .hex_en (HEX_EN != 0),
    .blank  (blank),
    .seg    (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= SEG_BLANK;
      dp  <= SEG_OFF;
      an  <= {N_DIGITS{AN_OFF}};
    end else begin
      seg <= dec_seg;
      dp  <= (blank || !cur_dp) ? SEG_OFF : SEG_ON;
      an  <= an_next;
    end
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter N_DIGITS, default 4: number of multiplexed digits, legal range 2..8.
REQ-002 Parameter REFRESH_DIV, default 100000: clock cycles per digit slot, minimum 2.
REQ-003 Parameter HEX_EN, default 0: 1 = show nibbles 10..15 as A,b,C,d,E,F; 0 = blank them.
REQ-004 Parameter LZ_BLANK, default 0: 1 = blank leading zeros.
REQ-005 Port clk, input, 1: single system clock. All logic is on the rising edge.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port load, input, 1: a 1-cycle strobe that captures value and dp_in.
REQ-008 Port value, input, 4*N_DIGITS: one nibble per digit; nibble 0 (bits 3:0) drives digit 0, the rightmost.
REQ-009 Port dp_in, input, N_DIGITS: per-digit decimal point request, 1 = lit.
REQ-010 Port seg, output, 7: the {a,b,c,d,e,f,g} pattern, active low, a at MSB.
REQ-011 Port dp, output, 1: decimal point, active low.
REQ-012 Port an, output, N_DIGITS: digit anodes, active low, one-hot-low while scanning.
REQ-013 Port frame_done, output, 1: a 1-cycle pulse at each frame boundary.

Function
REQ-014 The refresh counter SHALL count 0..REFRESH_DIV-1 and then wrap. On wrap, the digit index SHALL advance by one, from 0 to N_DIGITS-1, and wrap back to 0.
REQ-015 A frame boundary SHALL be the cycle in which the counter wraps while the index equals N_DIGITS-1. frame_done SHALL be high in exactly that cycle.
REQ-016 On load, value and dp_in SHALL be captured into a shadow register in the same cycle.
REQ-017 At a frame boundary, the shadow register SHALL be copied to the display register. The displayed data SHALL change only at frame boundaries (no tearing).
REQ-018 When load and a frame boundary occur in the same cycle, the new value and dp_in SHALL go directly to both the shadow and display registers.
REQ-019 When several loads occur within one frame, the last load SHALL win.
REQ-020 The digit decode for nibbles 0..9, active low {a..g}, SHALL be:
- 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
- 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
REQ-021 With HEX_EN=1, the decode SHALL be A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000. With HEX_EN=0, nibbles 10..15 SHALL produce seg=1111111.
REQ-022 With LZ_BLANK=1, every digit above the highest nonzero digit SHALL produce seg=1111111 and dp=1. Digit 0 is never blanked. The anode still scans normally.
REQ-023 seg, dp and an SHALL be registered. They reflect the index and display register of the previous cycle, giving a fixed latency of 1 cycle.
REQ-024 an SHALL have exactly one bit low per cycle outside reset. an[i]=0 while digit i is shown.

Reset
REQ-025 While rst=1, the block SHALL force:
- counter=0, index=0, shadow=0, display=0
- an=all ones, seg=1111111, dp=1, frame_done=0
REQ-026 rst SHALL override a load in the same cycle.
REQ-027 Scanning SHALL resume from digit 0 in the first cycle after rst falls. Outputs SHALL be valid one cycle later.
REQ-028 A reset asserted mid-frame SHALL discard any pending shadow data.

Structure
REQ-029 Package seg_pkg SHALL hold the sixteen segment-pattern constants, the SEG_BLANK constant (1111111), and the active-low polarity constants.
REQ-030 A combinational sub-module seg_nibble_decode (ports: nibble, hex_en, blank; output seg) SHALL implement REQ-020 and REQ-021. It is instantiated once, on the muxed digit.
REQ-031 The counter, index, shadow/display registers, leading-zero logic and output registers SHALL reside in seg_scan_driver.

Verification
Benches use N_DIGITS=4 and REFRESH_DIV=4, so one frame = 16 cycles.
REQ-032 Reset: rst=1 for 3 cycles, then release -> during reset an=1111, seg=1111111, dp=1, frame_done=0. One cycle after release, an=1110 and seg=0000001.
REQ-033 Scan: load value=16'h1234 at cycle 2 -> frame_done at cycle 15. In the next frame:
- an=1110, seg=1001100 ("4") for 4 cycles
- then an=1101, seg=0000110 ("3")
- then "2" on an=1011, then "1" on an=0111
- frame_done repeats every 16 cycles
REQ-034 Tear-free and simultaneous load:
- load 16'h5678 while digit 1 is active -> digits 2 and 3 still show the old data until frame_done; the next frame shows 8,7,6,5.
- load 16'h9999 in the frame_done cycle itself -> the following frame shows 9999.
REQ-035 Hex mode: value=16'h00AF, dp_in=4'b0001:
- HEX_EN=0 -> digits 0 and 1 show seg=1111111, and digit 0 has dp=0.
- HEX_EN=1 -> digit 0 shows 0111000 and digit 1 shows 0001000.
REQ-036 Leading-zero blanking with LZ_BLANK=1:
- value=16'h0040 -> digits 3 and 2 show 1111111, digit 1 shows "4", digit 0 shows "0".
- value=0 -> only digit 0 shows 0000001.
REQ-037 Reset mid-frame: assert rst while digit 2 is active, after a pending load -> the next cycle shows an=1111. After release, the scan restarts at digit 0 and displays 0000.
